seq_stage_controller: RTL
=========================

Name: seq_stage_controller

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ processor.
- Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, raising one stage enable per cycle.
- Owns the architectural PC register: selects and latches the next PC once per instruction.
- Tracks processor status (Stat), handshakes with data memory, and keeps cycle and instruction counters.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset and on start.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before an ADR fault; 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin execution from RESET_PC (honoured in IDLE or HALTED only).
- icode  input  4  decoded instruction code from fetch.
- instr_valid  input  1  fetch reports a legal icode/ifun.
- imem_error  input  1  fetch address out of range.
- cnd  input  1  condition result from execute.
- ValP  input  64  fall-through PC.
- ValC  input  64  constant word / jump target.
- ValM  input  64  value read from memory (return address).
- mem_ack  input  1  data memory access complete.
- dmem_error  input  1  data memory address fault, valid with mem_ack.
- pc  output  64  current PC, registered.
- fetch_en, decode_en, exec_en, wb_en  output  1 each  stage enables, at most one high per cycle.
- mem_req  output  1  data memory request, held until mem_ack.
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  output  1  high in any state other than IDLE/HALTED.
- cycle_count  output  32  cycles spent in non-IDLE/HALTED states, wraps.
- instr_count  output  32  instructions retired, wraps.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, stat=AOK, all enables and mem_req=0, counters=0. Reset mid-memory-access abandons the request with no completion.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- IDLE: on start, pc=RESET_PC, counters cleared, go to FETCH.
- FETCH: fetch_en=1. Faults are checked in priority order:
  - imem_error -> stat=ADR, go to HALTED.
  - !instr_valid or icode>4'hB -> stat=INS, go to HALTED.
  - icode==0 (halt) -> stat=HLT, instr_count+1, go to HALTED.
  - otherwise go to DECODE.
- DECODE: decode_en=1 for one cycle, then EXECUTE.
- EXECUTE: exec_en=1 for one cycle.
  - icode in {4,5,8,9,A,B} -> MEMORY.
  - otherwise -> WRITEBACK.
- MEMORY: mem_req=1 from entry until the cycle mem_ack is sampled high; an internal wait counter starts at 0 on entry.
  - mem_ack & dmem_error -> stat=ADR, go to HALTED.
  - mem_ack -> go to WRITEBACK.
  - wait counter reaches MEM_TIMEOUT without ack -> stat=ADR, go to HALTED.
- WRITEBACK: wb_en=1 for one cycle, then PCUPD.
- PCUPD: pc latched on the exit edge, instr_count+1, then FETCH. Next-PC selection:
  - icode 7: cnd ? ValC : ValP.
  - icode 8: ValC.
  - icode 9: ValM.
  - else: ValP.
- Latency: a non-memory instruction takes 5 cycles; a memory instruction takes 5 + k cycles, where k ≥ 1 is the mem_ack wait including the ack cycle.
- HALTED:
  - pc, stat and counters hold; no enables.
  - start restarts as from IDLE with stat=AOK.
  - start in any other state is ignored.
- stat changes only on the fault/halt transition and on restart. pc never changes on a faulting instruction.
- cycle_count increments on every clock edge while busy, wrapping 2^32-1 -> 0. instr_count wraps likewise.
- ValC, ValM, ValP and cnd are sampled only in PCUPD; they may change freely at other times.

Test Plan:
- Reset, start, icode=6 valid, ValP=0x2 -> enables sequence F,D,E,W over 4 cycles, pc=0x2 after cycle 5, instr_count=1, stat=1.
- icode=7 with cnd=1, ValC=0x40, ValP=0xA -> pc=0x40; repeat with cnd=0 -> pc=0xA.
- icode=9, mem_ack after 3 cycles, ValM=0x100 -> mem_req high exactly 3 cycles, pc=0x100, 8-cycle instruction.
- icode=5, mem_ack never asserted, MEM_TIMEOUT=15 -> mem_req drops, stat=3, HALTED, pc unchanged; start -> pc=RESET_PC, stat=1.
- Fetch faults:
  - icode=0 -> stat=2, busy=0, instr_count+1.
  - icode=0xC -> stat=4, instr_count unchanged.
  - imem_error=1 -> stat=3.
- rst_n pulsed low mid-MEMORY, asynchronous to clk -> all outputs at reset values immediately, no pc update; start afterwards runs normally.

Source files
------------

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ processor: walks one instruction
// through F/D/E/M/W/PC-update, owns the PC, status and cycle/instruction counters.
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | out of reset, waiting for start
// FETCH      | fetch_en, check fetch faults and halt
// DECODE     | decode_en for one cycle
// EXECUTE    | exec_en for one cycle, choose memory or writeback
// MEMORY     | mem_req held until ack, error or timeout
// WRITEBACK  | wb_en for one cycle
// PCUPD      | latch next PC, retire the instruction
// HALTED     | stopped on halt/fault, waiting for start
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        cnd,
  input  logic [63:0] ValP,
  input  logic [63:0] ValC,
  input  logic [63:0] ValM,
  input  logic        mem_ack,
  input  logic        dmem_error,
  output logic [63:0] pc,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        mem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_PCUPD     = 3'd6;
  localparam logic [2:0] ST_HALTED    = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Timeout runs as a down-counter: the last permitted wait cycle is terminal count 0.
  localparam logic [7:0] WAIT_LOAD = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state;
  logic [3:0]  icode_q;
  logic [7:0]  wait_left;
  logic        mem_op;
  logic [63:0] next_pc;

  assign fetch_en  = (state == ST_FETCH);
  assign decode_en = (state == ST_DECODE);
  assign exec_en   = (state == ST_EXECUTE);
  assign mem_req   = (state == ST_MEMORY);
  assign wb_en     = (state == ST_WRITEBACK);
  assign busy      = (state != ST_IDLE) && (state != ST_HALTED);

  always_comb begin
    mem_op = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_op = 1'b1;
      default:                            mem_op = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = ValP;
    case (icode_q)
      4'h7:    next_pc = cnd ? ValC : ValP;
      4'h8:    next_pc = ValC;
      4'h9:    next_pc = ValM;
      default: next_pc = ValP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      stat        <= STAT_AOK;
      icode_q     <= 4'h0;
      wait_left   <= 8'd0;
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (busy) cycle_count <= cycle_count + 32'd1;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            stat        <= STAT_AOK;
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
          end
        end
        ST_FETCH: begin
          icode_q <= icode;
          if (imem_error) begin
            stat  <= STAT_ADR;
            state <= ST_HALTED;
          end else if (!instr_valid || (icode > 4'hB)) begin
            stat  <= STAT_INS;
            state <= ST_HALTED;
          end else if (icode == 4'h0) begin
            stat        <= STAT_HLT;
            instr_count <= instr_count + 32'd1;
            state       <= ST_HALTED;
          end else begin
            state <= ST_DECODE;
          end
        end
        ST_DECODE: state <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (mem_op) begin
            state     <= ST_MEMORY;
            wait_left <= WAIT_LOAD;
          end else begin
            state <= ST_WRITEBACK;
          end
        end
        ST_MEMORY: begin
          if (mem_ack) begin
            if (dmem_error) begin
              stat  <= STAT_ADR;
              state <= ST_HALTED;
            end else begin
              state <= ST_WRITEBACK;
            end
          end else if (wait_left == 8'd0) begin
            stat  <= STAT_ADR;
            state <= ST_HALTED;
          end else begin
            wait_left <= wait_left - 8'd1;
          end
        end
        ST_WRITEBACK: state <= ST_PCUPD;
        ST_PCUPD: begin
          pc          <= next_pc;
          instr_count <= instr_count + 32'd1;
          state       <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
